// File: rtl/conversor_bcd_serial_pkg.sv
// Shared constants and state encoding for the serial binary-to-BCD converter.
// Widths and thresholds used by the top level and the digit corrector.
package conversor_bcd_serial_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        DESLOCA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    localparam int BITS   = 14;
    localparam int MAXIMO = 9999;
    localparam int LIMIAR = 5;
    localparam int AJUSTE = 3;

endpackage

// File: rtl/conversor_bcd_corrige_bcd.sv
// One double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more.
// Purely combinational, zero latency, no flow control.
module corrige_bcd
    import conversor_bcd_serial_pkg::*;
(
    input  logic [3:0] digito,
    output logic [3:0] corrigido
);

    assign corrigido = (digito >= 4'(LIMIAR)) ? digito + 4'(AJUSTE) : digito;

endmodule

// File: rtl/conversor_bcd_serial.sv
// Iterative 32-bit to 4-digit BCD converter with saturation at MAXIMO and start/done handshake.
// 14 edges from accept to valid outputs; inicio is ignored while ocupado is high.
module conversor_bcd_serial #(
    parameter int BITS   = conversor_bcd_serial_pkg::BITS,
    parameter int MAXIMO = conversor_bcd_serial_pkg::MAXIMO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inicio,
    input  logic [31:0] entrada,
    output logic        ocupado,
    output logic        pronto,
    output logic        estouro,
    output logic [3:0]  saida1,
    output logic [3:0]  saida2,
    output logic [3:0]  saida3,
    output logic [3:0]  saida4
);
    import conversor_bcd_serial_pkg::*;

    localparam logic [BITS-1:0] OPERANDO_MAX = BITS'(MAXIMO);
    localparam logic [3:0]      ULTIMA       = 4'(BITS - 1);

    estado_t         estado;
    estado_t         proximo;
    logic [3:0]      contador;
    logic [BITS-1:0] operando;
    logic [15:0]     scratch;
    logic [15:0]     corrigido;
    logic [15:0]     deslocado;
    logic            pendente;

    for (genvar i = 0; i < 4; i++) begin : g_corrige
        corrige_bcd u_corrige (
            .digito    (scratch[4*i +: 4]),
            .corrigido (corrigido[4*i +: 4])
        );
    end

    // Correct every digit first, then shift the next operand bit into the units.
    assign deslocado = {corrigido[14:0], operando[BITS-1]};

    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:  if (inicio) proximo = DESLOCA;
            DESLOCA: if (contador == ULTIMA) proximo = FIM;
            FIM:     proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    assign ocupado = (estado != OCIOSO);
    assign pronto  = (estado == FIM);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= OCIOSO;
            contador <= '0;
            operando <= '0;
            scratch  <= '0;
            pendente <= 1'b0;
            estouro  <= 1'b0;
            saida1   <= '0;
            saida2   <= '0;
            saida3   <= '0;
            saida4   <= '0;
        end else begin
            estado <= proximo;
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        contador <= '0;
                        scratch  <= '0;
                        if (entrada > 32'(MAXIMO)) begin
                            operando <= OPERANDO_MAX;
                            pendente <= 1'b1;
                        end else begin
                            operando <= entrada[BITS-1:0];
                            pendente <= 1'b0;
                        end
                    end
                end
                DESLOCA: begin
                    scratch  <= deslocado;
                    operando <= {operando[BITS-2:0], 1'b0};
                    contador <= contador + 4'd1;
                    if (contador == ULTIMA) begin
                        saida1  <= deslocado[3:0];
                        saida2  <= deslocado[7:4];
                        saida3  <= deslocado[11:8];
                        saida4  <= deslocado[15:12];
                        estouro <= pendente;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
